// File: rtl/instruction_memory_pkg.sv
// Shared types and constants for the instruction memory arbiter.
package instruction_memory_pkg;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } imem_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_LOAD  = 2'd2
  } imem_grant_t;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  // True when a byte address is misaligned or beyond the memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int abits);
    return (addr[1:0] != 2'b00) || ((addr >> abits) != 32'd0);
  endfunction

endpackage

// File: rtl/imem_rr_arbiter2.sv
// Two-requester round-robin grant (fetch vs load). The pointer only
// advances on a conflict, so the first conflict after reset grants fetch
// and later conflicts alternate; a lone requester is always granted.
module imem_rr_arbiter2
  import instruction_memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        load_req,
  output imem_grant_t grant
);

  logic prefer_load_q, prefer_load_d;

  // Grant selection and pointer update.
  always_comb begin
    grant         = GRANT_NONE;
    prefer_load_d = prefer_load_q;
    if (fetch_req && load_req) begin
      grant         = prefer_load_q ? GRANT_LOAD : GRANT_FETCH;
      prefer_load_d = ~prefer_load_q;
    end else if (fetch_req) begin
      grant = GRANT_FETCH;
    end else if (load_req) begin
      grant = GRANT_LOAD;
    end
  end

  // Last-grant pointer, fetch-first out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prefer_load_q <= 1'b0;
    else       prefer_load_q <= prefer_load_d;
  end

endmodule

// File: rtl/instruction_memory_arbiter.sv
// Boot/run sequencer and port arbiter for the single-port instruction memory.
// Optional feature macro: IMEM_RUNTIME_LOAD_EN (loads allowed in S_RUN,
// round-robin between fetch and load on conflict).
// Handshake: a port transfers in any cycle where request and ready are both
// high; ready is combinational from request and never depends on anything
// downstream. Fetch results appear exactly one cycle after the transfer.
module instruction_memory_arbiter
  import instruction_memory_pkg::*;
#(
  parameter int memory_size         = 1024,
  parameter int memory_address_bits = $clog2(memory_size)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_request,
  input  logic [31:0]                    fetch_pc,
  output logic                           fetch_ready,
  output logic                           fetch_valid,
  output logic [31:0]                    fetch_instruction,
  output logic                           fetch_fault,
  input  logic                           load_request,
  input  logic [31:0]                    load_address,
  input  logic [31:0]                    load_data,
  output logic                           load_ready,
  input  logic                           load_done,
  output logic                           load_fault,
  output logic                           core_run,
  output logic                           mem_read_enable,
  output logic                           mem_write_enable,
  output logic [memory_address_bits-3:0] mem_address,
  output logic [31:0]                    mem_write_data,
  input  logic [31:0]                    mem_read_data,
  output imem_state_t                    debug_state
);

  imem_state_t state_q, state_d;
  logic        core_run_q, core_run_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        load_fault_q, load_fault_d;
  logic [31:0] instr_hold_q, instr_hold_d;
  imem_grant_t grant;
  logic        fetch_bad, load_bad;

  assign fetch_bad = addr_bad(fetch_pc, memory_address_bits);
  assign load_bad  = addr_bad(load_address, memory_address_bits);

`ifdef IMEM_RUNTIME_LOAD_EN
  imem_grant_t rr_grant;

  imem_rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .fetch_req (fetch_request && (state_q == S_RUN)),
    .load_req  (load_request && (state_q == S_RUN)),
    .grant     (rr_grant)
  );

  // Run phase shares the port round-robin; boot phase serves only loads.
  always_comb begin
    grant = GRANT_NONE;
    if (state_q == S_RUN) grant = rr_grant;
    else if (load_request) grant = GRANT_LOAD;
  end
`else
  // Run phase serves only fetches; boot phase serves only loads.
  always_comb begin
    grant = GRANT_NONE;
    if (state_q == S_RUN) begin
      if (fetch_request) grant = GRANT_FETCH;
    end else if (load_request) begin
      grant = GRANT_LOAD;
    end
  end
`endif

  assign fetch_ready      = (grant == GRANT_FETCH);
  assign load_ready       = (grant == GRANT_LOAD);
  assign mem_read_enable  = fetch_ready && !fetch_bad;
  assign mem_write_enable = load_ready && !load_bad;
  assign mem_address      = load_ready ? load_address[memory_address_bits-1:2]
                                       : fetch_pc[memory_address_bits-1:2];
  assign mem_write_data   = load_data;

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign load_fault  = load_fault_q;
  assign core_run    = core_run_q;
  assign debug_state = state_q;

  // Read data is live in the response cycle, held afterwards.
  assign fetch_instruction = fetch_valid_q ?
                             (fetch_fault_q ? NOP_INSTRUCTION : mem_read_data) :
                             instr_hold_q;

  // Next-state: boot-to-run transition and one-cycle response flags.
  always_comb begin
    state_d       = state_q;
    core_run_d    = core_run_q;
    if ((state_q == S_BOOT) && load_done) begin
      state_d    = S_RUN;
      core_run_d = 1'b1;
    end
    fetch_valid_d = fetch_ready;
    fetch_fault_d = fetch_ready && fetch_bad;
    load_fault_d  = load_ready && load_bad;
    instr_hold_d  = fetch_instruction;
  end

  // FSM and registered outputs; reset drops any in-flight fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      core_run_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      load_fault_q  <= 1'b0;
      instr_hold_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      core_run_q    <= core_run_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_fault_q <= fetch_fault_d;
      load_fault_q  <= load_fault_d;
      instr_hold_q  <= instr_hold_d;
    end
  end

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// Directed bench for instruction_memory_arbiter with a synchronous memory model.
module tb_instruction_memory_arbiter;
  import instruction_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_request = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_instruction;
  logic        load_request = 1'b0;
  logic [31:0] load_address = 32'h0;
  logic [31:0] load_data = 32'h0;
  logic        load_ready, load_fault, core_run;
  logic        load_done = 1'b0;
  logic        mem_read_enable, mem_write_enable;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  imem_state_t debug_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock
  always #5 clk = ~clk;

  instruction_memory_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_request     (fetch_request),
    .fetch_pc          (fetch_pc),
    .fetch_ready       (fetch_ready),
    .fetch_valid       (fetch_valid),
    .fetch_instruction (fetch_instruction),
    .fetch_fault       (fetch_fault),
    .load_request      (load_request),
    .load_address      (load_address),
    .load_data         (load_data),
    .load_ready        (load_ready),
    .load_done         (load_done),
    .load_fault        (load_fault),
    .core_run          (core_run),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .debug_state       (debug_state)
  );

  // Synchronous single-port memory model
  logic [31:0] mem [256];
  logic [31:0] rd_q = 32'h0;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
    if (mem_read_enable)  rd_q <= mem[mem_address];
  end
  assign mem_read_data = rd_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_core_run", {31'd0, core_run}, 32'd0);
    check("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
    check("rst_ffault", {31'd0, fetch_fault}, 32'd0);
    check("rst_lfault", {31'd0, load_fault}, 32'd0);
    check("rst_instr", fetch_instruction, 32'h0);
    check("rst_state", 32'(debug_state), 32'(S_BOOT));
    check("rst_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    reset = 1'b0;
    #1;

    // Fetch during boot is stalled
    fetch_request = 1'b1; fetch_pc = 32'h0;
    #1;
    check("boot_fready", {31'd0, fetch_ready}, 32'd0);
    check("boot_rd_en", {31'd0, mem_read_enable}, 32'd0);
    tick();
    check("boot_fvalid", {31'd0, fetch_valid}, 32'd0);
    fetch_request = 1'b0;

    // Loads in boot
    load_request = 1'b1; load_address = 32'h0; load_data = 32'hAAAA0001;
    #1;
    check("ld0_ready", {31'd0, load_ready}, 32'd1);
    check("ld0_we", {31'd0, mem_write_enable}, 32'd1);
    check("ld0_addr", {24'd0, mem_address}, 32'd0);
    check("ld0_data", mem_write_data, 32'hAAAA0001);
    tick();
    check("ld0_lfault", {31'd0, load_fault}, 32'd0);

    // Out-of-range load
    load_address = 32'h800; load_data = 32'hDEADBEEF;
    #1;
    check("ldbad_ready", {31'd0, load_ready}, 32'd1);
    check("ldbad_we", {31'd0, mem_write_enable}, 32'd0);
    tick();
    check("ldbad_lfault", {31'd0, load_fault}, 32'd1);

    // Last load together with load_done
    load_address = 32'h4; load_data = 32'hBBBB0002; load_done = 1'b1;
    #1;
    check("ld1_we", {31'd0, mem_write_enable}, 32'd1);
    check("ld1_addr", {24'd0, mem_address}, 32'd1);
    check("done_core_run_lo", {31'd0, core_run}, 32'd0);
    tick();
    load_request = 1'b0; load_done = 1'b0;
    check("lfault_pulse_end", {31'd0, load_fault}, 32'd0);
    check("run_core_run", {31'd0, core_run}, 32'd1);
    check("run_state", 32'(debug_state), 32'(S_RUN));

    // Fetch 0x4 then back-to-back 0x0
    fetch_request = 1'b1; fetch_pc = 32'h4;
    #1;
    check("f4_ready", {31'd0, fetch_ready}, 32'd1);
    check("f4_rd_en", {31'd0, mem_read_enable}, 32'd1);
    check("f4_we", {31'd0, mem_write_enable}, 32'd0);
    check("f4_addr", {24'd0, mem_address}, 32'd1);
    tick();
    check("f4_valid", {31'd0, fetch_valid}, 32'd1);
    check("f4_fault", {31'd0, fetch_fault}, 32'd0);
    check("f4_instr", fetch_instruction, 32'hBBBB0002);
    fetch_pc = 32'h0;
    #1;
    check("f0_rd_en", {31'd0, mem_read_enable}, 32'd1);
    tick();
    fetch_request = 1'b0;
    check("f0_valid", {31'd0, fetch_valid}, 32'd1);
    check("f0_instr", fetch_instruction, 32'hAAAA0001);
    tick();
    check("idle_valid", {31'd0, fetch_valid}, 32'd0);
    check("idle_hold", fetch_instruction, 32'hAAAA0001);

    // Faulting fetches: misaligned then out of range
    fetch_request = 1'b1; fetch_pc = 32'h2;
    #1;
    check("fmis_ready", {31'd0, fetch_ready}, 32'd1);
    check("fmis_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();
    check("fmis_valid", {31'd0, fetch_valid}, 32'd1);
    check("fmis_fault", {31'd0, fetch_fault}, 32'd1);
    check("fmis_instr", fetch_instruction, 32'h00000013);
    fetch_pc = 32'h400;
    #1;
    check("foor_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();
    fetch_request = 1'b0;
    check("foor_valid", {31'd0, fetch_valid}, 32'd1);
    check("foor_fault", {31'd0, fetch_fault}, 32'd1);
    check("foor_instr", fetch_instruction, 32'h00000013);
    tick();
    check("fault_idle_valid", {31'd0, fetch_valid}, 32'd0);
    check("fault_idle_hold", fetch_instruction, 32'h00000013);

`ifdef IMEM_RUNTIME_LOAD_EN
    // Conflict: grants F, L, F, L
    fetch_request = 1'b1; fetch_pc = 32'h0;
    load_request = 1'b1; load_address = 32'h8; load_data = 32'hDEAD0008;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_fready", {31'd0, fetch_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_lready", {31'd0, load_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_excl", {31'd0, mem_read_enable & mem_write_enable}, 32'd0);
      tick();
    end
    fetch_request = 1'b0;
    // Runtime write then immediate fetch
    load_data = 32'h12345678;
    #1;
    check("rtl_we", {31'd0, mem_write_enable}, 32'd1);
    tick();
    load_request = 1'b0;
    fetch_request = 1'b1; fetch_pc = 32'h8;
    tick();
    fetch_request = 1'b0;
    check("rtl_valid", {31'd0, fetch_valid}, 32'd1);
    check("rtl_instr", fetch_instruction, 32'h12345678);
`else
    // Runtime load blocked
    load_request = 1'b1; load_address = 32'h8; load_data = 32'h12345678;
    #1;
    check("blk_lready", {31'd0, load_ready}, 32'd0);
    check("blk_we", {31'd0, mem_write_enable}, 32'd0);
    tick();
    check("blk_lfault", {31'd0, load_fault}, 32'd0);
    load_request = 1'b0;
    fetch_request = 1'b1; fetch_pc = 32'h8;
    tick();
    fetch_request = 1'b0;
    check("blk_valid", {31'd0, fetch_valid}, 32'd1);
    check("blk_instr", fetch_instruction, 32'h0);
`endif
    tick();

    // Reset the cycle after a fetch is accepted
    fetch_request = 1'b1; fetch_pc = 32'h4;
    tick();
    fetch_request = 1'b0;
    reset = 1'b1;
    #1;
    check("mrst_valid", {31'd0, fetch_valid}, 32'd0);
    check("mrst_core_run", {31'd0, core_run}, 32'd0);
    check("mrst_state", 32'(debug_state), 32'(S_BOOT));
    check("mrst_instr", fetch_instruction, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("mrst_valid_after", {31'd0, fetch_valid}, 32'd0);
    check("mrst_state_after", 32'(debug_state), 32'(S_BOOT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory_arbiter.md
# instruction_memory_arbiter

Sequencing and sharing controller for the single-port instruction memory. After reset it holds the core in a boot phase in which only the program loader may write the memory. Once the loader signals completion it releases the core and serves instruction fetches with one-cycle latency. It sits between the fetch stage, the program loader and the instruction memory wiring, and is the only block driving the memory's control and address lines.

## Interface
- `memory_size`, 1024: memory size in bytes.
- `memory_address_bits`, `$clog2(memory_size)`: byte-address bits. The memory index is `[memory_address_bits-1:2]`.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `fetch_request`, in, 1: fetch stage requests the instruction at `fetch_pc`.
- `fetch_pc`, in, 32: byte address of the instruction.
- `fetch_ready`, out, 1: the fetch request is accepted this cycle.
- `fetch_valid`, out, 1: `fetch_instruction` is valid this cycle.
- `fetch_instruction`, out, 32: the fetched word.
- `fetch_fault`, out, 1: qualifies `fetch_valid`. The fetch was misaligned or out of range.
- `load_request`, in, 1: loader requests a write.
- `load_address`, in, 32: byte address of the write.
- `load_data`, in, 32: word to write.
- `load_ready`, out, 1: the load is accepted this cycle.
- `load_done`, in, 1: single-cycle pulse marking the end of the program image.
- `load_fault`, out, 1: one-cycle pulse for a rejected load.
- `core_run`, out, 1: high once boot is complete.
- `mem_read_enable`, out, 1: memory read strobe.
- `mem_write_enable`, out, 1: memory write strobe.
- `mem_address`, out, `memory_address_bits-2`: memory word index.
- `mem_write_data`, out, 32: data to write.
- `mem_read_data`, in, 32: read data from a synchronous memory, valid the cycle after the read.

## Operation
- FSM states:
  - `S_BOOT`, the reset state: loads are served and fetches are stalled (`fetch_ready` = 0).
  - `S_RUN`: fetches are served.
- Transition: `load_done` sampled high in `S_BOOT` moves the FSM to `S_RUN` on the next edge. `S_RUN` leaves only on `reset`.
- A load accepted in the same cycle as `load_done` is performed.
- Address check, applied to both ports:
  - Misaligned: `addr[1:0]` ≠ 0.
  - Out of range: any bit of `addr[31:memory_address_bits]` set.
- Accepted valid fetch: `mem_read_enable` = 1 and `mem_address` = `fetch_pc[memory_address_bits-1:2]`, combinationally in the accept cycle.
- Accepted invalid fetch:
  - No memory access.
  - Next cycle: `fetch_valid` = 1, `fetch_fault` = 1, `fetch_instruction` = `NOP_INSTRUCTION` (32'h00000013).
- Accepted valid load: `mem_write_enable` = 1, with `mem_address` and `mem_write_data` driven from the load port in the accept cycle.
- Accepted invalid load: no write. `load_fault` pulses the next cycle.
- Only one memory operation happens per cycle. The read and write strobes are never high together.
- `fetch_instruction` holds its last value while `fetch_valid` = 0.

## Timing
- Reset values:
  - `core_run`, `fetch_valid`, `fetch_fault`, `load_fault`: 0.
  - `fetch_instruction`: 32'h0.
  - FSM: `S_BOOT`.
  - Round-robin pointer: fetch-first.
  - Memory strobes: 0 while no request is pending.
- Fetch accepted in cycle N: `fetch_valid` = 1 in N+1. `fetch_instruction` = `mem_read_data` in N+1 and is captured for holding afterwards.
- Back-to-back fetches sustain 1 per cycle.
- Load accepted in N: the write completes at the end of N. A fetch of the same address accepted in N+1 returns the new data.
- `core_run` rises in the cycle after `load_done`.
- `reset` asserted mid-operation:
  - All registered outputs clear immediately.
  - An in-flight fetch is discarded: no `fetch_valid` after reset.
  - The FSM returns to `S_BOOT`.

## Configuration
- Macro: `IMEM_RUNTIME_LOAD_EN`.
- Defined:
  - Loads are also accepted in `S_RUN`.
  - When `fetch_request` and `load_request` are both high, grants alternate round-robin. The first conflict after entering `S_RUN` grants fetch.
  - A lone requester is always granted.
- Undefined:
  - In `S_RUN`, `load_ready` = 0 and load requests are ignored without a fault.
  - `fetch_ready` = `fetch_request`.

## Structure
- Package `instruction_memory_pkg` holds:
  - the state enum `imem_state_t` (`S_BOOT`, `S_RUN`);
  - the grant enum `imem_grant_t` (`GRANT_NONE`, `GRANT_FETCH`, `GRANT_LOAD`);
  - `NOP_INSTRUCTION`.
- Sub-module `imem_rr_arbiter2`: a two-requester round-robin grant with a registered last-grant pointer. It is instantiated only under `IMEM_RUNTIME_LOAD_EN`.

## Test plan
- Boot, then fetch:
  - Stimulus: load words 32'hAAAA0001 to addr 0x0 and 32'hBBBB0002 to addr 0x4, pulse `load_done`, then fetch 0x4.
  - Required: `core_run` rises the cycle after `load_done`; `fetch_valid` one cycle after the accept with 32'hBBBB0002.
- Fetch in boot:
  - Stimulus: `fetch_request` = 1 before `load_done`.
  - Required: `fetch_ready` = 0, no `mem_read_enable`, no `fetch_valid`.
- Faults:
  - Stimulus: fetch 0x2, then fetch 0x400 with `memory_size` = 1024.
  - Required: each returns `fetch_valid` = 1, `fetch_fault` = 1, instruction 32'h00000013, with no memory strobe.
  - Stimulus: load to 0x800.
  - Required: `load_fault` pulses, no write.
- Reset mid-fetch:
  - Stimulus: assert `reset` the cycle after a fetch is accepted.
  - Required: `fetch_valid` stays 0, `core_run` = 0, state `S_BOOT`.
- Runtime load (`IMEM_RUNTIME_LOAD_EN` defined):
  - Stimulus: in `S_RUN`, hold fetch and load requests high for 4 cycles.
  - Required: grants F, L, F, L.
  - Stimulus: write 32'h12345678 to 0x8, then fetch 0x8 the next cycle.
  - Required: 32'h12345678 is returned.
- Runtime load blocked (macro undefined):
  - Stimulus: in `S_RUN`, hold `load_request` high.
  - Required: `load_ready` = 0, no write, no `load_fault`.
